// File: rtl/comp_share_ctrl_if.sv
// Bundles the request, comparator and response channels of comp_share_ctrl.
// slave is the controller side; master is the requester/comparator/consumer side.
interface comp_share_ctrl_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic [DATA_WIDTH-1:0]         cmp_din_a;
   logic [DATA_WIDTH-1:0]         cmp_din_b;
   logic                          cmp_equal;
   logic                          cmp_greater;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_WIDTH-1:0]           rsp_id;
   logic                          rsp_equal;
   logic                          rsp_greater;
   logic                          rsp_error;
   logic                          busy;

   modport slave (
      input  req_valid, req_a, req_b, cmp_equal, cmp_greater, rsp_ready,
      output req_ready, cmp_din_a, cmp_din_b, rsp_valid, rsp_id,
             rsp_equal, rsp_greater, rsp_error, busy
   );

   modport master (
      output req_valid, req_a, req_b, cmp_equal, cmp_greater, rsp_ready,
      input  req_ready, cmp_din_a, cmp_din_b, rsp_valid, rsp_id,
             rsp_equal, rsp_greater, rsp_error, busy
   );
endinterface

// File: rtl/comp_share_ctrl.sv
// Round-robin sharing of one magnitude comparator between NUM_REQ requesters:
// accept, hold operands for a settle cycle, capture the result, hand it back tagged.
module comp_share_ctrl #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2
) (
   input  logic             clk,
   input  logic             rst,
   comp_share_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

   state_t                state_reg, state_next;
   logic [ID_WIDTH-1:0]   last_grant_reg;
   logic [ID_WIDTH-1:0]   grant_id_reg;
   logic [DATA_WIDTH-1:0] cmp_a_reg, cmp_b_reg;
   logic                  rsp_valid_reg;
   logic [ID_WIDTH-1:0]   rsp_id_reg;
   logic                  rsp_equal_reg, rsp_greater_reg, rsp_error_reg;

   logic [ID_WIDTH-1:0]   hi_idx, lo_idx, pick_idx;
   logic                  hi_found, any_valid, accept;
   logic [NUM_REQ-1:0]    ready_c;
   logic                  busy_c;
   logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
   logic [DATA_WIDTH-1:0] op_b [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign op_a[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
         assign op_b[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Round robin: lowest valid index above last_grant wins, else wrap to lowest valid.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            lo_idx = ID_WIDTH'(i);
            if (ID_WIDTH'(i) > last_grant_reg) begin
               hi_found = 1'b1;
               hi_idx   = ID_WIDTH'(i);
            end
         end
      end
   end

   assign pick_idx  = hi_found ? hi_idx : lo_idx;
   assign any_valid = |bus.req_valid;
   assign accept    = (state_reg == IDLE) && any_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      ready_c    = '0;
      busy_c     = 1'b1;
      case (state_reg)
         IDLE: begin
            busy_c = 1'b0;
            if (any_valid) begin
               state_next = SETTLE;
               if (!rst) ready_c[pick_idx] = 1'b1;
            end
         end
         SETTLE:  state_next = CAPTURE;
         CAPTURE: state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg  <= ID_WIDTH'(NUM_REQ - 1);
         grant_id_reg    <= '0;
         cmp_a_reg       <= '0;
         cmp_b_reg       <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_id_reg      <= '0;
         rsp_equal_reg   <= 1'b0;
         rsp_greater_reg <= 1'b0;
         rsp_error_reg   <= 1'b0;
      end else begin
         if (accept) begin
            cmp_a_reg      <= op_a[pick_idx];
            cmp_b_reg      <= op_b[pick_idx];
            grant_id_reg   <= pick_idx;
            last_grant_reg <= pick_idx;
         end
         // The comparator has had the whole SETTLE cycle to resolve by now.
         if (state_reg == CAPTURE) begin
            rsp_valid_reg   <= 1'b1;
            rsp_id_reg      <= grant_id_reg;
            rsp_equal_reg   <= bus.cmp_equal;
            rsp_greater_reg <= bus.cmp_greater;
            rsp_error_reg   <= bus.cmp_equal & bus.cmp_greater;
         end
         if (state_reg == RESP && bus.rsp_ready) rsp_valid_reg <= 1'b0;
      end
   end

   assign bus.req_ready   = ready_c;
   assign bus.busy        = busy_c;
   assign bus.cmp_din_a   = cmp_a_reg;
   assign bus.cmp_din_b   = cmp_b_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_id      = rsp_id_reg;
   assign bus.rsp_equal   = rsp_equal_reg;
   assign bus.rsp_greater = rsp_greater_reg;
   assign bus.rsp_error   = rsp_error_reg;
endmodule

// File: tb/tb_comp_share_ctrl.sv
// Bench for comp_share_ctrl: table vectors, directed corner sequences and random
// traffic, all checked against a transaction-timeline model of the scheduler.
module tb_comp_share_ctrl;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic fault_en;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   comp_share_ctrl_if #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(2)) bus ();

   comp_share_ctrl #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural comparator, with a fault mode that asserts both outputs.
   assign bus.cmp_equal   = fault_en | (bus.cmp_din_a == bus.cmp_din_b);
   assign bus.cmp_greater = fault_en | (bus.cmp_din_a > bus.cmp_din_b);

   // Model: age = cycles since the last accept, -1 while the scheduler is free.
   int         m_last, age, m_id;
   logic [7:0] m_a, m_b;
   logic       m_eq, m_gt, m_err;
   int         grants[$];
   int         gcyc[$];

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      logic       flt;
      logic       eq;
      logic       gt;
      logic       err;
   } vec_t;
   vec_t tbl[9];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_last = N - 1;
      age    = -1;
      m_a    = 8'h00;
      m_b    = 8'h00;
      grants.delete();
      gcyc.delete();
   endfunction

   task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] a,
                       input logic [N*W-1:0] b, input logic rr, input logic flt);
      logic [N-1:0] exp_ready;
      int win, idx;
      rst = r; bus.req_valid = v; bus.req_a = a; bus.req_b = b;
      bus.rsp_ready = rr; fault_en = flt;
      @(negedge clk);
      exp_ready = '0;
      win = -1;
      if (!r && age < 0) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_last + 1 + k) % N;
            if (v[idx] && win < 0) win = idx;
         end
         if (win >= 0) exp_ready[win] = 1'b1;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("busy", 32'(bus.busy), 32'(age >= 0));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(age >= 2));
      chk("cmp_din_a", 32'(bus.cmp_din_a), 32'(m_a));
      chk("cmp_din_b", 32'(bus.cmp_din_b), 32'(m_b));
      if (age >= 2) begin
         chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
         chk("rsp_equal", 32'(bus.rsp_equal), 32'(m_eq));
         chk("rsp_greater", 32'(bus.rsp_greater), 32'(m_gt));
         chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
      end
      @(posedge clk);
      if (r) model_reset();
      else if (win >= 0) begin
         m_a = a[win*W +: W];
         m_b = b[win*W +: W];
         m_last = win;
         age = 0;
         grants.push_back(win);
         gcyc.push_back(cyc);
      end else if (age == 0) age = 1;
      else if (age == 1) begin
         m_eq  = flt | (m_a == m_b);
         m_gt  = flt | (m_a > m_b);
         m_err = m_eq & m_gt;
         m_id  = m_last;
         age   = 2;
      end else if (age >= 2) begin
         if (rr) age = -1;
         else    age++;
      end
      cyc++;
      #1;
   endtask

   task automatic run_vec(input vec_t t);
      logic [N*W-1:0] av, bv;
      logic [N-1:0]   v;
      av = $urandom; bv = $urandom;
      av[t.id*W +: W] = t.a;
      bv[t.id*W +: W] = t.b;
      v = '0;
      v[t.id] = 1'b1;
      step(1'b0, v, av, bv, 1'b1, t.flt);
      step(1'b0, '0, av, bv, 1'b1, t.flt);
      step(1'b0, '0, av, bv, 1'b1, t.flt);
      chk("tbl_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tbl_id", 32'(bus.rsp_id), 32'(t.id));
      chk("tbl_din_a", 32'(bus.cmp_din_a), 32'(t.a));
      chk("tbl_equal", 32'(bus.rsp_equal), 32'(t.eq));
      chk("tbl_greater", 32'(bus.rsp_greater), 32'(t.gt));
      chk("tbl_error", 32'(bus.rsp_error), 32'(t.err));
      $display("vec id=%0d a=%02h b=%02h flt=%0d -> eq=%0d gt=%0d err=%0d", t.id, t.a, t.b,
               t.flt, bus.rsp_equal, bus.rsp_greater, bus.rsp_error);
      step(1'b0, '0, av, bv, 1'b1, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 5; k++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [N*W-1:0] ra, rb;
      int n;
      model_reset();
      tbl[0] = '{2, 8'h05, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{3, 8'hFF, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{0, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{3, 8'hAA, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{2, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8] = '{2, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset with every requester asking: nothing may be granted.
      step(1'b1, '1, '1, '1, 1'b1, 1'b0);
      step(1'b1, '1, '1, '1, 1'b1, 1'b0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_flags", 32'({bus.rsp_equal, bus.rsp_greater, bus.rsp_error}), 32'd0);
      $display("reset done busy=%0d rsp_valid=%0d", bus.busy, bus.rsp_valid);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Continuous contention straight out of reset.
      step(1'b1, '0, '0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, '1, $urandom, $urandom, 1'b1, 1'b0);
      chk("cont_count", 32'(grants.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < grants.size(); k++) begin
         chk("cont_order", 32'(grants[k]), 32'(k % N));
         if (k > 0) chk("cont_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
         $display("contention grant %0d -> id %0d at cycle %0d", k, grants[k], gcyc[k]);
      end
      drain();

      // Backpressure: five stalled RESP cycles with other requesters waiting.
      ra = $urandom; rb = $urandom;
      step(1'b0, 4'b0100, ra, rb, 1'b1, 1'b0);
      step(1'b0, '0, ra, rb, 1'b1, 1'b0);
      step(1'b0, '0, ra, rb, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 4'b1010, ra, rb, 1'b0, 1'b0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_id", 32'(bus.rsp_id), 32'd2);
      step(1'b0, 4'b1010, ra, rb, 1'b1, 1'b0);
      step(1'b0, 4'b1010, ra, rb, 1'b1, 1'b0);
      n = grants.size();
      chk("bp_next_id", 32'(grants[n-1]), 32'd3);
      chk("bp_next_gap", 32'(gcyc[n-1] - gcyc[n-2]), 32'd9);
      $display("backpressure next grant id=%0d gap=%0d", grants[n-1], gcyc[n-1] - gcyc[n-2]);
      drain();

      // Reset while in SETTLE abandons the transaction.
      ra = {8'h00, 8'h00, 8'h5A, 8'h00};
      rb = {8'h00, 8'h00, 8'hC3, 8'h00};
      step(1'b0, 4'b0010, ra, rb, 1'b1, 1'b0);
      step(1'b1, '0, ra, rb, 1'b1, 1'b0);
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_din_a", 32'(bus.cmp_din_a), 32'd0);
      chk("mid_rst_din_b", 32'(bus.cmp_din_b), 32'd0);
      step(1'b0, 4'b0011, ra, rb, 1'b1, 1'b0);
      chk("mid_rst_prio", 32'(grants.size() == 1 && grants[0] == 0), 32'd1);
      $display("reset mid-transaction: first grant after reset id=%0d", grants[0]);
      drain();

      // Random traffic, including occasional resets and comparator faults.
      for (int k = 0; k < 2500; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rb = ra;
         step(($urandom_range(0, 199) == 0), 4'($urandom), ra, rb,
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      end
      $display("random phase: %0d grants since last reset", grants.size());
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/comp_share_ctrl.md
# comp_share_ctrl

Round-robin scheduler that shares one 8-bit magnitude comparator (equal / greater-than datapath) between several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, drives the comparator inputs from registers, waits one settle cycle, and captures the result. It then returns the result, tagged with the requester index, through a valid/ready response channel. It sits between the requesting control units and the single comparator instance, which is the only path to that comparator.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, operand width
- ID_WIDTH, 2, width of rsp_id; must equal clog2(NUM_REQ)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand B; same slicing as req_a
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high
- cmp_din_a  out  DATA_WIDTH  registered operand A to the comparator
- cmp_din_b  out  DATA_WIDTH  registered operand B to the comparator
- cmp_equal  in  1  comparator result, a == b
- cmp_greater  in  1  comparator result, a > b (unsigned)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_WIDTH  index of the requester being answered
- rsp_equal  out  1  captured cmp_equal
- rsp_greater  out  1  captured cmp_greater
- rsp_error  out  1  captured cmp_equal & cmp_greater (illegal comparator output)
- busy  out  1  high in every state except IDLE

## Operation
- FSM states and transitions:
  - IDLE -> SETTLE when any req_valid is high.
  - SETTLE -> CAPTURE unconditionally.
  - CAPTURE -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready is high; otherwise stay in RESP.
- Arbitration in IDLE:
  - Round-robin search starts at index (last_grant+1) mod NUM_REQ and picks the first index i with req_valid[i].
  - req_ready[i] is asserted combinationally in that cycle only, so the accept happens on that edge.
- On accept:
  - cmp_din_a and cmp_din_b load requester i's operand slices.
  - The winner index is stored in grant_id.
  - last_grant is set to i.
- SETTLE: cmp_din_a and cmp_din_b are held stable and the comparator output is ignored.
- CAPTURE edge: rsp_equal, rsp_greater, rsp_error load from cmp_equal, cmp_greater, and their AND; rsp_id loads grant_id; rsp_valid is set.
- RESP: all rsp_* outputs are held stable until rsp_ready is high. On that edge rsp_valid clears.
- Operands in cmp_din_a and cmp_din_b keep their last value after a transaction; they are not cleared.
- req_ready is 0 in SETTLE, CAPTURE and RESP, and 0 whenever rst is high.
- A requester that drops req_valid before it is granted is simply skipped; it has no state in this block.
- Comparison is unsigned; widths are not extended or truncated.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), grant_id=0.
  - cmp_din_a=0, cmp_din_b=0.
  - rsp_valid=0, rsp_id=0, rsp_equal=0, rsp_greater=0, rsp_error=0, busy=0, req_ready=0.
- Latency, with E0 being the accept edge (req_valid[i] & req_ready[i]):
  - Operands appear on cmp_din after E0.
  - Results are captured at E0+2.
  - rsp_valid is high from E0+2 onward.
- Throughput:
  - With rsp_ready held high, back-to-back accepts occur every 4 cycles (E0, E0+4, ...).
  - Each RESP cycle with rsp_ready low adds one cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous contention, grants rotate in strict index order.
- Reset mid-operation: the in-flight transaction is abandoned with no response; all registers return to their reset values at the reset edge.
- The comparator path from cmp_din to cmp_equal/cmp_greater is combinational and must settle within one clock period.

## Test plan
- Single request: req_valid[2]=1, a=0x05, b=0x03 -> req_ready[2] pulses for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_greater=1, rsp_equal=0, rsp_error=0.
- Equal and less-than cases: a=0x00,b=0x00 gives rsp_equal=1, rsp_greater=0; a=0x00,b=0x01 gives both 0; a=0xFF,b=0xFE gives rsp_greater=1 (unsigned).
- Contention: all 4 req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0, spaced 4 cycles apart; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_* outputs are stable, busy=1, req_ready stays 0, no new grant; the response completes on the cycle rsp_ready rises, and the next accept happens 1 cycle later.
- Reset mid-transaction: assert rst in SETTLE -> next cycle rsp_valid=0, busy=0, cmp_din_a=cmp_din_b=0, and requester 0 has first priority again.
- Faulty comparator model driving cmp_equal=cmp_greater=1 -> rsp_error=1 with rsp_valid, while normal sequencing continues.
